// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the pipelined miniRISC ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_NEG = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 2;
  localparam int FLG_V = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between decode/regfile read (master) and alu_pipe (slave).
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  // Valid/ready on both sides: a beat transfers on a rising edge where valid && ready;
  // the sender keeps valid and payload stable until that edge, and valid never waits on ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, shamt, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, shamt, op, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic               busy_q,   busy_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) busy_d = 1'b0;
    end
  end

  // The final step's sum is handed out combinationally so the owner can register it on the last edge.
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_step;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus an iterative MUL.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus,
  output alu_state_e dbg_state
);

  alu_state_e         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic               in_ready;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    mul_start = accept && (bus.op == OP_MUL);
  end

  always_comb begin
    sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NEG: alu_r = ~bus.b + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_AND: alu_r = bus.a & bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_SUB: begin
        alu_r = diff_w[WIDTH-1:0];
        alu_c = diff_w[WIDTH];
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SRL: alu_r = bus.a >> bus.shamt;
      OP_SLL: alu_r = bus.a << bus.shamt;
      OP_SRA: alu_r = $unsigned($signed(bus.a) >>> bus.shamt);
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_r = '0;
    endcase
  end

  // A single-cycle accept and a MUL completion are exclusive: accepts only happen in IDLE.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (accept && (bus.op != OP_MUL)) begin
      out_valid_d    = 1'b1;
      result_d       = alu_r;
      flags_d[FLG_C] = alu_c;
      flags_d[FLG_V] = alu_v;
      flags_d[FLG_S] = alu_r[WIDTH-1];
      flags_d[FLG_Z] = (alu_r == '0);
    end else if (mul_done) begin
      out_valid_d    = 1'b1;
      result_d       = mul_product[WIDTH-1:0];
      flags_d[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
      flags_d[FLG_V] = 1'b0;
      flags_d[FLG_S] = mul_product[WIDTH-1];
      flags_d[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed corner cases, back-pressure, reset mid-MUL, then random ops.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  alu_state_e dbg_state;
  int         checks   = 0;
  int         failures = 0;
  logic [35:0] exp_q[$];
  logic       rand_ready_en = 1'b0;
  logic       rand_ready_bit = 1'b1;
  logic       ready_force = 1'b1;
  logic       mon_hold_v = 1'b0;
  logic [36:0] mon_prev = '0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb bus.out_ready = rand_ready_en ? rand_ready_bit : ready_force;

  always begin
    @(negedge clk);
    rand_ready_bit = ($urandom_range(0, 3) != 0);
  end

  // ---------------- reference model ----------------
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [63:0] w;
    longint      s;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        w = 64'(a) + 64'(b);
        r = w[31:0];
        c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd1: r = 32'd0 - b;
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      4'd4: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd5: r = a >> sh;
      4'd6: r = a << sh;
      4'd7: r = $signed(a) >>> sh;
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: begin
        w = 64'(a) * 64'(b);
        r = w[31:0];
        c = (w[63:32] != 64'd0);
      end
      default: r = 32'd0;
    endcase
    return {v, r[31], (r == 32'd0), c, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always begin
    @(negedge clk);
    #2;
    if (rst_n !== 1'b1) begin
      mon_hold_v = 1'b0;
    end else begin
      if (mon_hold_v) chk("hold_stable", 40'({bus.out_valid, bus.flags, bus.result}), 40'(mon_prev));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("spurious_output", 40'(exp_q.size()), 40'd1);
        else chk("scoreboard", 40'({bus.flags, bus.result}), 40'(exp_q.pop_front()));
      end
      mon_hold_v = bus.out_valid && !bus.out_ready;
      mon_prev   = {bus.out_valid, bus.flags, bus.result};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    #1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_accept"}, 40'(n < 200), 40'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [35:0] exp, input string tag);
    exp_q.push_back(exp);
    drive_req(op, a, b, sh);
    wait_accept(tag);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_drained"}, 40'(exp_q.size()), 40'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int busy_hi;
    int st_bad;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_sh;

    rst_n     = 1'b0;
    bus.in_valid = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.shamt = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  40'(bus.in_ready), 40'd0);
    chk("rst_out_valid", 40'(bus.out_valid), 40'd0);
    chk("rst_result",    40'(bus.result), 40'd0);
    chk("rst_flags",     40'(bus.flags), 40'd0);
    chk("rst_state",     40'(dbg_state), 40'(ST_IDLE));
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    send_exp(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, {4'b0011, 32'h0000_0000}, "add_wrap");
    chk("add_latency", 40'(bus.out_valid), 40'd1);
    send_exp(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, {4'b1100, 32'h8000_0000}, "add_ovf");
    send_exp(OP_SUB, 32'd5, 32'd7, 5'd0, {4'b0100, 32'hFFFF_FFFE}, "sub_neg");
    send_exp(OP_SUB, 32'd7, 32'd7, 5'd0, {4'b0011, 32'h0000_0000}, "sub_eq");
    send_exp(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, {4'b0000, 32'h0000_0001}, "slt_neg");
    send_exp(OP_SRA, 32'h8000_0000, 32'd0, 5'd4, {4'b0100, 32'hF800_0000}, "sra");
    send_exp(OP_NEG, 32'd0, 32'd1, 5'd0, {4'b0100, 32'hFFFF_FFFF}, "neg");
    send_exp(4'd12, 32'h1234_5678, 32'h1, 5'd3, {4'b0010, 32'h0000_0000}, "reserved");
    wait_drain("directed");

    send_exp(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, {4'b0011, 32'h0000_0000}, "mul_big");
    n = 0;
    busy_hi = 0;
    st_bad = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) busy_hi++;
      if (dbg_state != ST_MUL) st_bad++;
      n++;
      @(negedge clk);
    end
    chk("mul_latency", 40'(n), 40'd32);
    chk("mul_in_ready_low", 40'(busy_hi), 40'd0);
    chk("mul_state", 40'(st_bad), 40'd0);
    send_exp(OP_MUL, 32'd7, 32'd6, 5'd0, {4'b0000, 32'd42}, "mul_small");
    wait_drain("mul");

    ready_force = 1'b0;
    send_exp(OP_ADD, 32'd1, 32'd2, 5'd0, {4'b0000, 32'd3}, "bp1");
    exp_q.push_back({4'b0000, 32'd30});
    drive_req(OP_ADD, 32'd10, 32'd20, 5'd0);
    repeat (4) begin
      #1;
      chk("bp_in_ready", 40'(bus.in_ready), 40'd0);
      chk("bp_held", 40'({bus.out_valid, bus.result}), 40'({1'b1, 32'd3}));
      @(negedge clk);
    end
    ready_force = 1'b1;
    wait_accept("bp2");
    chk("bp_refill", 40'({bus.out_valid, bus.result}), 40'({1'b1, 32'd30}));
    send_exp(OP_ADD, 32'd100, 32'd200, 5'd0, {4'b0000, 32'd300}, "bp3");
    chk("bp_third", 40'({bus.out_valid, bus.result}), 40'({1'b1, 32'd300}));
    wait_drain("bp");

    drive_req(OP_MUL, 32'h1234, 32'h5678, 5'd0);
    wait_accept("mul_abort");
    repeat (9) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 40'(bus.out_valid), 40'd0);
    chk("abort_in_ready",  40'(bus.in_ready), 40'd0);
    chk("abort_state",     40'(dbg_state), 40'(ST_IDLE));
    @(negedge clk);
    #1;
    chk("abort_regs", 40'({bus.out_valid, bus.flags, bus.result}), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 40'(bus.in_ready), 40'd1);
    @(negedge clk);
    send_exp(OP_MUL, 32'd3, 32'd5, 5'd0, {4'b0000, 32'd15}, "mul_after_rst");
    wait_drain("abort");

    rand_ready_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = pick();
      r_b  = pick();
      r_sh = 5'($urandom_range(0, 31));
      send_exp(r_op, r_a, r_b, r_sh, model(r_op, r_a, r_b, r_sh), "rand");
    end
    rand_ready_en = 1'b0;
    ready_force = 1'b1;
    wait_drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
